// File: rtl/video_palout_if.sv
// Signal bundle between the renderer / palette writer and the video output stage.
// The master side drives colour, timing and palette-write signals; the slave side drives the pins.
interface video_palout_if;
  logic [3:0] zxcolor;
  logic [3:0] zxborder;
  logic       hpix;
  logic       vpix;
  logic       hblank;
  logic       vblank;
  logic       hsync;
  logic       vsync;
  logic       pal_en;
  logic       atm_palwr;
  logic [5:0] atm_paldata;
  logic [1:0] vred;
  logic [1:0] vgrn;
  logic [1:0] vblu;
  logic       vhsync;
  logic       vvsync;
  logic       vcsync;

  modport master (
    output zxcolor, zxborder, hpix, vpix, hblank, vblank, hsync, vsync,
           pal_en, atm_palwr, atm_paldata,
    input  vred, vgrn, vblu, vhsync, vvsync, vcsync
  );

  modport slave (
    input  zxcolor, zxborder, hpix, vpix, hblank, vblank, hsync, vsync,
           pal_en, atm_palwr, atm_paldata,
    output vred, vgrn, vblu, vhsync, vvsync, vcsync
  );
endinterface

// File: rtl/video_palout.sv
// Final video output stage: pixel/border select, ATM palette or fixed ZX colour mapping,
// blanking and composite sync, with colour and sync pins sharing a fixed 2-clock latency.
module video_palout #(
  parameter int SYNC_POL = 0
) (
  input logic           clk,
  input logic           rst,
  video_palout_if.slave vif
);

  localparam logic SYNC_INV = (SYNC_POL == 0);

  // Fixed ZX mapping, packed {G, R, B} like a palette entry; bright adds the low bit.
  function automatic logic [5:0] default_rgb(input logic [3:0] idx);
    return {idx[2], idx[2] & idx[3],
            idx[1], idx[1] & idx[3],
            idx[0], idx[0] & idx[3]};
  endfunction

  logic [5:0] pal [16];

  logic [3:0] s1_idx;
  logic       s1_blk;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_cs;

  logic [5:0] rgb_next;

  // Palette lives in flops so reset can restore every entry in a single clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        pal[i] <= default_rgb(4'(i));
      end
    end else if (vif.atm_palwr) begin
      pal[vif.zxborder] <= vif.atm_paldata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_idx <= '0;
      s1_blk <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_cs  <= 1'b0;
    end else begin
      s1_idx <= (vif.hpix && vif.vpix) ? vif.zxcolor : vif.zxborder;
      s1_blk <= vif.hblank | vif.vblank;
      s1_hs  <= vif.hsync;
      s1_vs  <= vif.vsync;
      s1_cs  <= vif.vsync ? ~vif.hsync : vif.hsync;
    end
  end

  // The palette is read before any same-edge write lands, so a colliding write shows up one clock later.
  always_comb begin
    rgb_next = '0;
    if (!s1_blk) begin
      rgb_next = vif.pal_en ? pal[s1_idx] : default_rgb(s1_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vif.vred   <= '0;
      vif.vgrn   <= '0;
      vif.vblu   <= '0;
      vif.vhsync <= SYNC_INV;
      vif.vvsync <= SYNC_INV;
      vif.vcsync <= SYNC_INV;
    end else begin
      vif.vgrn   <= rgb_next[5:4];
      vif.vred   <= rgb_next[3:2];
      vif.vblu   <= rgb_next[1:0];
      vif.vhsync <= s1_hs ^ SYNC_INV;
      vif.vvsync <= s1_vs ^ SYNC_INV;
      vif.vcsync <= s1_cs ^ SYNC_INV;
    end
  end

endmodule

// File: tb/tb_video_palout.sv
// Self-checking bench for video_palout: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural reference model.
module tb_video_palout;

  localparam int SYNC_POL = 0;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  video_palout_if vif ();

  video_palout #(.SYNC_POL(SYNC_POL)) dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference colour mapping, packed {G,R,B} to match palette write data.
  function automatic logic [5:0] ref_default(input int idx);
    int i_bit, g, r, b;
    i_bit = (idx >> 3) & 1;
    g = ((idx >> 2) & 1) * 2 + (((idx >> 2) & 1) & i_bit);
    r = ((idx >> 1) & 1) * 2 + (((idx >> 1) & 1) & i_bit);
    b = (idx & 1) * 2 + ((idx & 1) & i_bit);
    return 6'(g * 16 + r * 4 + b);
  endfunction

  function automatic logic pin_level(input logic active);
    return (SYNC_POL != 0) ? active : !active;
  endfunction

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] color, input logic [3:0] border,
                                input logic hp, input logic vp, input logic hb, input logic vb,
                                input logic hs, input logic vs, input logic pe, input logic wr,
                                input logic [5:0] data);
    vif.zxcolor     = color;
    vif.zxborder    = border;
    vif.hpix        = hp;
    vif.vpix        = vp;
    vif.hblank      = hb;
    vif.vblank      = vb;
    vif.hsync       = hs;
    vif.vsync       = vs;
    vif.pal_en      = pe;
    vif.atm_palwr   = wr;
    vif.atm_paldata = data;
  endtask

  // Reference model: a palette array plus the pixel captured one edge earlier,
  // resolved into colour at the following edge using that edge's pal_en and palette.
  logic [5:0] mpal [16];
  logic [3:0] pend_idx;
  logic       pend_blk, pend_hs, pend_vs;
  logic [5:0] exp_rgb;
  logic       exp_hs, exp_vs, exp_cs;
  bit         have_exp = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mpal[i] = ref_default(i);
      pend_idx = 4'd0;
      pend_blk = 1'b0;
      pend_hs  = 1'b0;
      pend_vs  = 1'b0;
      exp_rgb  = 6'd0;
      exp_hs   = pin_level(1'b0);
      exp_vs   = pin_level(1'b0);
      exp_cs   = pin_level(1'b0);
      have_exp = 1;
    end else if (have_exp) begin
      if (pend_blk) exp_rgb = 6'd0;
      else exp_rgb = vif.pal_en ? mpal[pend_idx] : ref_default(int'(pend_idx));
      exp_hs = pin_level(pend_hs);
      exp_vs = pin_level(pend_vs);
      exp_cs = pin_level(pend_vs ? !pend_hs : pend_hs);
      if (vif.atm_palwr) mpal[vif.zxborder] = vif.atm_paldata;
      pend_idx = (vif.hpix && vif.vpix) ? vif.zxcolor : vif.zxborder;
      pend_blk = vif.hblank || vif.vblank;
      pend_hs  = vif.hsync;
      pend_vs  = vif.vsync;
    end
  end

  always @(negedge clk) begin
    if (have_exp) begin
      check_output("model_rgb", {2'b00, vif.vred, vif.vgrn, vif.vblu},
                   {2'b00, exp_rgb[3:2], exp_rgb[5:4], exp_rgb[1:0]});
      check_output("model_sync", {5'd0, vif.vhsync, vif.vvsync, vif.vcsync},
                   {5'd0, exp_hs, exp_vs, exp_cs});
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    apply_stimulus(4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h00);
    repeat (2) @(negedge clk);
    check_output("reset_rgb", {2'b00, vif.vred, vif.vgrn, vif.vblu}, 8'h00);
    check_output("reset_sync", {5'd0, vif.vhsync, vif.vvsync, vif.vcsync}, 8'h07);

    rst = 1'b0;
    apply_stimulus(4'hA, 4'h0, 1, 1, 0, 0, 0, 0, 0, 0, 6'h00);
    repeat (2) @(negedge clk);
    check_output("default_A", {2'b00, vif.vred, vif.vgrn, vif.vblu}, 8'b00_11_00_00);
    check_output("idle_sync", {5'd0, vif.vhsync, vif.vvsync, vif.vcsync}, 8'h07);

    apply_stimulus(4'h0, 4'h5, 0, 0, 0, 0, 0, 0, 0, 1, 6'b01_10_11);
    @(negedge clk);
    apply_stimulus(4'h0, 4'h5, 0, 0, 0, 0, 0, 0, 1, 0, 6'h00);
    repeat (2) @(negedge clk);
    check_output("border_pal5", {2'b00, vif.vred, vif.vgrn, vif.vblu}, 8'b00_10_01_11);
    apply_stimulus(4'h5, 4'h0, 1, 1, 0, 0, 0, 0, 1, 0, 6'h00);
    repeat (2) @(negedge clk);
    check_output("pixel_pal5", {2'b00, vif.vred, vif.vgrn, vif.vblu}, 8'b00_10_01_11);

    apply_stimulus(4'h3, 4'h3, 1, 1, 0, 0, 0, 0, 1, 0, 6'h00);
    @(negedge clk);
    apply_stimulus(4'h3, 4'h3, 1, 1, 0, 0, 0, 0, 1, 1, 6'b01_01_01);
    @(negedge clk);
    check_output("collision_old", {2'b00, vif.vred, vif.vgrn, vif.vblu}, 8'b00_10_00_10);
    apply_stimulus(4'h3, 4'h3, 1, 1, 0, 0, 0, 0, 1, 0, 6'h00);
    @(negedge clk);
    check_output("collision_new", {2'b00, vif.vred, vif.vgrn, vif.vblu}, 8'b00_01_01_01);

    apply_stimulus(4'hF, 4'h0, 1, 1, 1, 0, 1, 0, 0, 0, 6'h00);
    repeat (2) @(negedge clk);
    check_output("blank_rgb", {2'b00, vif.vred, vif.vgrn, vif.vblu}, 8'h00);
    check_output("blank_hsync", {7'd0, vif.vhsync}, 8'h00);

    apply_stimulus(4'h0, 4'h0, 0, 0, 0, 0, 1, 1, 0, 0, 6'h00);
    @(negedge clk);
    vif.hsync = 1'b0;
    @(negedge clk);
    check_output("csync_v1_a", {7'd0, vif.vcsync}, 8'h01);
    check_output("vsync_pin", {7'd0, vif.vvsync}, 8'h00);
    vif.hsync = 1'b1;
    @(negedge clk);
    check_output("csync_v1_b", {7'd0, vif.vcsync}, 8'h00);
    @(negedge clk);
    check_output("csync_v1_c", {7'd0, vif.vcsync}, 8'h01);

    apply_stimulus(4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0, 6'h00);
    @(negedge clk);
    vif.hsync = 1'b0;
    @(negedge clk);
    check_output("csync_v0_a", {7'd0, vif.vcsync}, 8'h00);
    vif.hsync = 1'b1;
    @(negedge clk);
    check_output("csync_v0_b", {7'd0, vif.vcsync}, 8'h01);
    @(negedge clk);
    check_output("csync_v0_c", {7'd0, vif.vcsync}, 8'h00);

    apply_stimulus(4'h0, 4'h7, 0, 0, 0, 0, 0, 0, 0, 1, 6'h3F);
    @(negedge clk);
    apply_stimulus(4'h7, 4'h7, 1, 1, 0, 0, 0, 0, 1, 0, 6'h00);
    rst = 1'b1;
    @(negedge clk);
    check_output("in_reset_rgb", {2'b00, vif.vred, vif.vgrn, vif.vblu}, 8'h00);
    check_output("in_reset_sync", {5'd0, vif.vhsync, vif.vvsync, vif.vcsync}, 8'h07);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_reload7", {2'b00, vif.vred, vif.vgrn, vif.vblu}, 8'b00_10_10_10);

    for (int n = 0; n < 3000; n++) begin
      apply_stimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                     6'($urandom_range(0, 63)));
      rst = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end

    rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
